// File: rtl/filter_sequencer.sv
// Sequences a moving-sum filter: flush on start, one step per sample, drop warm-up results.
// Latency: accept -> out_valid 3 cycles; backpressure holds the result and counts dropped ADC samples.
// Backpressure: in_ready is low outside WAIT_IN; HOLD waits indefinitely for out_ready.
module filter_sequencer #(
    parameter int DATA_W       = 12,
    parameter int ORDER        = 5,
    parameter int FLUSH_CYCLES = ORDER + 1,
    parameter int WARMUP       = 2,
    parameter int OVR_W        = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              filt_clear,
    output logic              filt_step,
    output logic [DATA_W-1:0] filt_data_in,
    input  logic [DATA_W-1:0] filt_data_out,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic [OVR_W-1:0]  overrun_count
);

    localparam int FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam int WU_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_WAIT_IN,
        S_STEP,
        S_CAPTURE,
        S_HOLD
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [FL_W-1:0] flush_cnt;
    logic [WU_W-1:0] warm_cnt;
    logic            flush_last;
    logic            warming;

    assign flush_last = (flush_cnt == FL_W'(FLUSH_CYCLES - 1));
    assign warming    = (int'(warm_cnt) < WARMUP);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (enable) state_nxt = S_FLUSH;
            S_FLUSH:   if (flush_last) state_nxt = S_WAIT_IN;
            S_WAIT_IN: begin
                // enable drop wins over a sample presented in the same cycle
                if (!enable)       state_nxt = S_IDLE;
                else if (in_valid) state_nxt = S_STEP;
            end
            S_STEP:    state_nxt = S_CAPTURE;
            S_CAPTURE: begin
                if (warming) state_nxt = enable ? S_WAIT_IN : S_IDLE;
                else         state_nxt = S_HOLD;
            end
            S_HOLD:    if (out_ready) state_nxt = enable ? S_WAIT_IN : S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they align with state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            in_ready      <= 1'b0;
            filt_clear    <= 1'b0;
            filt_step     <= 1'b0;
            out_valid     <= 1'b0;
            busy          <= 1'b0;
            filt_data_in  <= '0;
            out_data      <= '0;
            overrun_count <= '0;
            flush_cnt     <= '0;
            warm_cnt      <= '0;
        end else begin
            state      <= state_nxt;
            in_ready   <= (state_nxt == S_WAIT_IN);
            filt_clear <= (state_nxt == S_FLUSH);
            filt_step  <= (state_nxt == S_STEP);
            out_valid  <= (state_nxt == S_HOLD);
            busy       <= (state_nxt != S_IDLE);

            if (state == S_IDLE && enable) begin
                flush_cnt <= '0;
                warm_cnt  <= '0;
            end else if (state == S_FLUSH && !flush_last) begin
                flush_cnt <= flush_cnt + 1'b1;
            end

            if (state == S_WAIT_IN && enable && in_valid)
                filt_data_in <= in_data;

            if (state == S_CAPTURE) begin
                if (warming) warm_cnt <= warm_cnt + 1'b1;
                else         out_data <= filt_data_out;
            end

            // Dropped samples: offered while busy but not accepted.
            if (in_valid && !in_ready && state != S_IDLE && overrun_count != '1)
                overrun_count <= overrun_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_filter_sequencer.sv
// Directed bench for filter_sequencer with a 3-sample moving-sum filter model.
// A second instance covers the no-warm-up, single-cycle-flush build.
module tb_filter_sequencer;

    logic        clock = 1'b0;
    logic        reset, enable, in_valid, in_ready, filt_clear, filt_step;
    logic        out_valid, out_ready, busy;
    logic [11:0] in_data, filt_data_in, filt_data_out, out_data;
    logic [7:0]  overrun_count;

    logic        b_reset, b_enable, b_in_valid, b_in_ready, b_filt_clear, b_filt_step;
    logic        b_out_valid, b_out_ready, b_busy;
    logic [11:0] b_in_data, b_filt_data_in, b_filt_data_out, b_out_data;
    logic [7:0]  b_overrun_count;

    logic [11:0] h1, h2, b_h1, b_h2;
    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    filter_sequencer dut (
        .clock(clock), .reset(reset), .enable(enable),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .filt_clear(filt_clear), .filt_step(filt_step),
        .filt_data_in(filt_data_in), .filt_data_out(filt_data_out),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .overrun_count(overrun_count)
    );

    filter_sequencer #(.WARMUP(0), .FLUSH_CYCLES(1)) dut_b (
        .clock(clock), .reset(b_reset), .enable(b_enable),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .filt_clear(b_filt_clear), .filt_step(b_filt_step),
        .filt_data_in(b_filt_data_in), .filt_data_out(b_filt_data_out),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
        .busy(b_busy), .overrun_count(b_overrun_count)
    );

    // 3-sample moving-sum filters; result registered on the step edge.
    always @(posedge clock) begin
        if (reset || filt_clear) begin
            h1 <= '0; h2 <= '0; filt_data_out <= '0;
        end else if (filt_step) begin
            h1 <= filt_data_in; h2 <= h1;
            filt_data_out <= filt_data_in + h1 + h2;
        end
    end

    always @(posedge clock) begin
        if (b_reset || b_filt_clear) begin
            b_h1 <= '0; b_h2 <= '0; b_filt_data_out <= '0;
        end else if (b_filt_step) begin
            b_h1 <= b_filt_data_in; b_h2 <= b_h1;
            b_filt_data_out <= b_filt_data_in + b_h1 + b_h2;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Counts filt_clear cycles until in_ready rises (bounded).
    task automatic wait_flush(input string tag, input int exp_cycles);
        int n = 0;
        for (int k = 0; k < 50 && !in_ready; k++) begin
            tick();
            if (filt_clear) n++;
        end
        check_eq({tag, "_clear_cycles"}, n, exp_cycles);
        check_eq({tag, "_in_ready"}, in_ready, 1);
    endtask

    // Offers one sample from WAIT_IN and follows it to HOLD or back to WAIT_IN.
    task automatic feed(input string tag, input logic [11:0] d, input bit exp_out, input logic [11:0] exp_val);
        int cyc = 0;
        int steps = 0;
        in_data  = d;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            in_valid = 1'b0;
            cyc++;
            if (filt_step) steps++;
            if (cyc == 1) check_eq({tag, "_din"}, filt_data_in, d);
            if (out_valid || in_ready) break;
        end
        check_eq({tag, "_lat"}, cyc, 3);
        check_eq({tag, "_steps"}, steps, 1);
        check_eq({tag, "_ovld"}, out_valid, exp_out);
        if (exp_out) check_eq({tag, "_odat"}, out_data, exp_val);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int stable_err;
        int n;
        int cyc;
        reset = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        b_reset = 1'b1; b_enable = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        tick(); tick();

        // Reset state
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_clear", filt_clear, 0);
        check_eq("rst_step", filt_step, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ovr", overrun_count, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_din", filt_data_in, 0);

        // Start: 6-cycle flush
        reset = 1'b0; enable = 1'b1;
        wait_flush("start", 6);

        // Warm-up drops 2 results, then 3-sample sums
        out_ready = 1'b1;
        feed("s1", 12'd1, 1'b0, 12'd0);
        feed("s2", 12'd2, 1'b0, 12'd0);
        feed("s3", 12'd3, 1'b1, 12'd6);
        tick();
        feed("s4", 12'd4, 1'b1, 12'd9);
        tick();
        feed("s5", 12'd5, 1'b1, 12'd12);
        tick();

        // Backpressure with dropped samples, then saturation
        out_ready = 1'b0;
        feed("s6", 12'd6, 1'b1, 12'd15);
        in_valid = 1'b1; in_data = 12'd99;
        stable_err = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (!out_valid || out_data !== 12'd15) stable_err++;
        end
        check_eq("bp_ovr10", overrun_count, 10);
        check_eq("bp_stable", stable_err, 0);
        for (int k = 0; k < 300; k++) tick();
        check_eq("bp_ovr_sat", overrun_count, 255);
        check_eq("bp_still_valid", out_valid, 1);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check_eq("bp_released", out_valid, 0);
        check_eq("bp_back_wait", in_ready, 1);
        check_eq("bp_din_kept", filt_data_in, 6);

        // Enable drop in HOLD: result still delivered, then IDLE
        out_ready = 1'b0;
        feed("s7", 12'd7, 1'b1, 12'd18);
        enable = 1'b0;
        tick(); tick(); tick();
        check_eq("drop_hold_valid", out_valid, 1);
        check_eq("drop_hold_data", out_data, 18);
        out_ready = 1'b1;
        tick();
        check_eq("drop_idle_busy", busy, 0);
        check_eq("drop_idle_valid", out_valid, 0);
        check_eq("drop_idle_ready", in_ready, 0);
        tick();
        check_eq("drop_idle_noclear", filt_clear, 0);

        // Re-enable: reflush and warm-up again
        enable = 1'b1;
        wait_flush("reen", 6);
        feed("r1", 12'd7, 1'b0, 12'd0);
        feed("r2", 12'd7, 1'b0, 12'd0);
        feed("r3", 12'd7, 1'b1, 12'd21);
        tick();

        // Reset during STEP
        in_data = 12'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq("rs_in_step", filt_step, 1);
        reset = 1'b1;
        tick();
        check_eq("rs_step_busy", busy, 0);
        check_eq("rs_step_nostep", filt_step, 0);
        check_eq("rs_step_ovr", overrun_count, 0);
        check_eq("rs_step_clear", filt_clear, 0);
        reset = 1'b0;
        wait_flush("rs_reflush", 6);

        // Reset during HOLD
        out_ready = 1'b0;
        feed("h1", 12'd1, 1'b0, 12'd0);
        feed("h2", 12'd1, 1'b0, 12'd0);
        feed("h3", 12'd1, 1'b1, 12'd3);
        in_valid = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        check_eq("rh_ovr2", overrun_count, 2);
        reset = 1'b1;
        tick();
        check_eq("rh_valid", out_valid, 0);
        check_eq("rh_ovr", overrun_count, 0);
        check_eq("rh_busy", busy, 0);
        check_eq("rh_step", filt_step, 0);

        // No overrun counting in IDLE
        enable = 1'b0;
        tick();
        reset = 1'b0; in_valid = 1'b1;
        tick(); tick(); tick();
        in_valid = 1'b0;
        check_eq("idle_ovr", overrun_count, 0);
        check_eq("idle_busy", busy, 0);
        check_eq("idle_noclear", filt_clear, 0);

        // No-warm-up, single-cycle flush instance
        check_eq("b_rst_busy", b_busy, 0);
        b_reset = 1'b0; b_enable = 1'b1; b_out_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 50 && !b_in_ready; k++) begin
            tick();
            if (b_filt_clear) n++;
        end
        check_eq("b_clear_cycles", n, 1);
        check_eq("b_in_ready", b_in_ready, 1);
        b_in_data = 12'd4; b_in_valid = 1'b1;
        cyc = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            b_in_valid = 1'b0;
            cyc++;
            if (b_out_valid || b_in_ready) break;
        end
        check_eq("b_lat", cyc, 3);
        check_eq("b_ovld", b_out_valid, 1);
        check_eq("b_odat", b_out_data, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
